bcd_scan_counter: RTL and testbench

- 4-digit synchronous BCD up/down counter with parallel load, plus a time-multiplexed digit scanner.
- Sits directly upstream of the BCD-to-7-segment decoder. Each scan slot presents one digit as A,B,C,D (A = MSB) with enable E, and asserts a one-hot digit-select for the display anodes/cathodes.
- Sequencing lives here; segment decoding stays downstream.

---
 rtl/bcd_scan_counter.sv | 133 +++++++++++++
 tb/tb_bcd_scan_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// NUM_DIGITS-digit BCD up/down counter with parallel load and a digit scanner
// that feeds A..D/E and a one-hot digit select to a downstream 7-seg decoder.
module bcd_digit (
    input  logic [3:0] d,
    input  logic       cin,
    input  logic       up,
    output logic [3:0] q,
    output logic       cout
);
    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d == 4'd9) begin
                    q    = 4'd0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q    = 4'd9;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_scan_counter #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    count_en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic                    blank_lz,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    carry,
    output logic                    A,
    output logic                    B,
    output logic                    C,
    output logic                    D,
    output logic                    E,
    output logic [NUM_DIGITS-1:0]   dig_sel
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PSC_BLK  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [NUM_DIGITS-1:0][3:0] dig, dig_step, ld_clean;
    logic [NUM_DIGITS:0]        chain;

    assign chain[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_digit u_dig (
            .d    (dig[g]),
            .cin  (chain[g]),
            .up   (up_dn),
            .q    (dig_step[g]),
            .cout (chain[g+1])
        );
        assign ld_clean[g] = (load_val[4*g +: 4] > 4'd9) ? 4'd0 : load_val[4*g +: 4];
    end

    // Ripple out of the top digit is exactly the wrap condition in either direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig   <= '0;
            carry <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (load) begin
                dig <= ld_clean;
            end else if (count_en) begin
                dig   <= dig_step;
                carry <= chain[NUM_DIGITS];
            end
        end
    end

    assign value = dig;

    logic [PW-1:0]       psc, psc_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic                psc_wrap, blk;
    logic [NUM_DIGITS:0] hz;
    logic [3:0]          nib;

    assign psc_wrap = (psc == PSC_LAST);
    assign psc_nxt  = psc_wrap ? '0 : psc + PW'(1);
    assign idx_nxt  = psc_wrap ? ((idx == IDX_LAST) ? '0 : idx + IW'(1)) : idx;

    // hz[j]: digit j and every digit above it are zero.
    always_comb begin
        hz             = '0;
        hz[NUM_DIGITS] = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 0; j--)
            hz[j] = hz[j+1] && (dig[j] == 4'd0);
    end

    assign blk = blank_lz && (idx_nxt != '0) && hz[idx_nxt];

    // Outputs are built from next-state slot info so E/A..D line up with dig_sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc     <= '0;
            idx     <= '0;
            dig_sel <= NUM_DIGITS'(1);
            nib     <= 4'd0;
            E       <= 1'b0;
        end else begin
            psc <= psc_nxt;
            idx <= idx_nxt;
            if (psc_wrap)
                dig_sel <= {dig_sel[NUM_DIGITS-2:0], dig_sel[NUM_DIGITS-1]};
            nib <= dig[idx_nxt];
            E   <= (psc_nxt >= PSC_BLK) && !blk;
        end
    end

    assign {A, B, C, D} = nib;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with a decimal-arithmetic reference model
// checked against every output on every falling edge.
module tb_bcd_scan_counter;
    localparam int N   = 4;
    localparam int SD  = 4;
    localparam int BLK = 1;
    localparam int MOD = 10000;

    logic          clk = 1'b0, rst = 1'b1;
    logic          count_en = 1'b0, up_dn = 1'b1, load = 1'b0, blank_lz = 1'b0;
    logic [4*N-1:0] load_val = '0;
    logic [4*N-1:0] value;
    logic          carry, A, B, C, D, E;
    logic [N-1:0]  dig_sel;

    int npass = 0, ntot = 0;

    bcd_scan_counter #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BLK)) dut (
        .clk(clk), .rst(rst), .count_en(count_en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .blank_lz(blank_lz), .value(value), .carry(carry),
        .A(A), .B(B), .C(C), .D(D), .E(E), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r *= 10;
        return r;
    endfunction

    function automatic int from_bcd(input logic [4*N-1:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) begin
            int nb = int'(v[4*i +: 4]);
            if (nb > 9) nb = 0;
            r += nb * pow10(i);
        end
        return r;
    endfunction

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    // Reference model: decimal value, edges since reset, and what was visible
    // on the previous edge (scanned digits lag the count by one cycle).
    int m_val = 0, m_prev = 0, k = 0;
    bit m_carry = 0, m_blz = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_val = 0; m_prev = 0; k = 0; m_carry = 0; m_blz = 0;
        end else begin
            m_prev  = m_val;
            m_blz   = blank_lz;
            m_carry = 0;
            k++;
            if (load) m_val = from_bcd(load_val);
            else if (count_en) begin
                if (up_dn) begin
                    if (m_val == MOD - 1) begin m_val = 0; m_carry = 1; end
                    else m_val++;
                end else begin
                    if (m_val == 0) begin m_val = MOD - 1; m_carry = 1; end
                    else m_val--;
                end
            end
        end
    end

    always @(negedge clk) begin
        int psc, idx, dv;
        bit exp_e;
        psc   = k % SD;
        idx   = (k / SD) % N;
        dv    = (m_prev / pow10(idx)) % 10;
        exp_e = (psc >= BLK) && !(m_blz && idx > 0 && (m_prev / pow10(idx)) == 0);
        chk("value",   32'(value),        32'(to_bcd(m_val)));
        chk("carry",   32'(carry),        32'(m_carry));
        chk("dig_sel", 32'(dig_sel),      32'(1 << idx));
        chk("abcd",    32'({A, B, C, D}), 32'(dv));
        chk("E",       32'(E),            32'(exp_e));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [4*N-1:0] v);
        load_val = v; load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    int ecnt[N];
    int nib_bad;

    task automatic observe_slots(input logic [3:0] n1, input logic [3:0] n0);
        for (int s = 0; s < N; s++) ecnt[s] = 0;
        nib_bad = 0;
        for (int c = 0; c < 16; c++) begin
            tick(1);
            for (int s = 0; s < N; s++)
                if (dig_sel[s] && E) begin
                    ecnt[s]++;
                    if (s == 1 && {A, B, C, D} != n1) nib_bad++;
                    if (s == 0 && {A, B, C, D} != n0) nib_bad++;
                end
        end
    endtask

    initial begin
        int guard;
        // 1: reset state, then idle scan
        tick(1);
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_sel",   32'(dig_sel), 32'h1);
        chk("rst_E",     32'(E), 32'h0);
        chk("rst_carry", 32'(carry), 32'h0);
        rst = 1'b0;
        tick(1);
        chk("t1_sel0", 32'(dig_sel), 32'h1);
        chk("t1_E_on", 32'(E), 32'h1);
        tick(3);
        chk("t1_sel1", 32'(dig_sel), 32'h2);
        chk("t1_E_blank", 32'(E), 32'h0);
        tick(16);

        // 2: load and ripple up
        do_load(16'h0998);
        chk("t2_load", 32'(value), 32'h0998);
        count_en = 1'b1; up_dn = 1'b1;
        tick(1); chk("t2_0999", 32'(value), 32'h0999);
        tick(1); chk("t2_1000", 32'(value), 32'h1000);
        tick(1); chk("t2_1001", 32'(value), 32'h1001);
        count_en = 1'b0;

        // 3: wrap both ways
        do_load(16'h9999);
        count_en = 1'b1; up_dn = 1'b1;
        tick(1); count_en = 1'b0;
        chk("t3_up_wrap", 32'(value), 32'h0000);
        chk("t3_up_carry", 32'(carry), 32'h1);
        tick(1); chk("t3_carry_drop", 32'(carry), 32'h0);
        do_load(16'h0000);
        count_en = 1'b1; up_dn = 1'b0;
        tick(1); count_en = 1'b0;
        chk("t3_dn_wrap", 32'(value), 32'h9999);
        chk("t3_dn_carry", 32'(carry), 32'h1);
        tick(1); chk("t3_carry_drop2", 32'(carry), 32'h0);

        // 4: invalid nibbles and load priority
        do_load(16'h0A5F);
        chk("t4_sanitize", 32'(value), 32'h0050);
        count_en = 1'b1; up_dn = 1'b1;
        do_load(16'h0123);
        count_en = 1'b0;
        chk("t4_load_wins", 32'(value), 32'h0123);
        chk("t4_no_carry", 32'(carry), 32'h0);

        // 5: leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0042);
        tick(4);
        observe_slots(4'd4, 4'd2);
        chk("t5_e3", 32'(ecnt[3]), 32'd0);
        chk("t5_e2", 32'(ecnt[2]), 32'd0);
        chk("t5_e1", 32'(ecnt[1]), 32'd3);
        chk("t5_e0", 32'(ecnt[0]), 32'd3);
        chk("t5_nib", 32'(nib_bad), 32'd0);
        do_load(16'h0000);
        tick(4);
        observe_slots(4'd0, 4'd0);
        chk("t5z_e321", 32'(ecnt[3] + ecnt[2] + ecnt[1]), 32'd0);
        chk("t5z_e0", 32'(ecnt[0]), 32'd3);
        blank_lz = 1'b0;

        // 6: async reset mid slot 2 while counting
        count_en = 1'b1; up_dn = 1'b1;
        guard = 0;
        while (dig_sel != 4'b0100 && guard < 40) begin tick(1); guard++; end
        if (guard >= 40) chk("t6_reach_slot2", 32'(dig_sel), 32'h4);
        tick(1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_value", 32'(value), 32'h0);
        chk("t6_rst_sel",   32'(dig_sel), 32'h1);
        chk("t6_rst_E",     32'(E), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("t6_resume_val", 32'(value), 32'h0001);
        chk("t6_resume_sel", 32'(dig_sel), 32'h1);
        chk("t6_resume_E",   32'(E), 32'h1);
        tick(8);
        count_en = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
